// File: rtl/if_id_stage.sv
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register with load-use hazard detection,
//            branch flush and saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrc,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  output logic [31:0]      pc_out,
  output logic [31:0]      instr_out,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic             valid_out,
  output logic             pc_write,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hazard;

  // rt is compared regardless of opcode: conservative, avoids decoding here.
  assign hazard = ex_MemRead & valid_q & (ex_rt != 5'd0) &
                  ((ex_rt == instr_q[25:21]) | (ex_rt == instr_q[20:16]));

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    pc_write = 1'b1;
    bubble   = 1'b0;
    if (PCSrc) begin
      // ID/EX zeroes its own controls on PCSrc, so no bubble is requested.
      pc_d    = pc_in;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (flush_q != CNT_MAX) flush_d = flush_q + CNT_ONE;
    end else if (hazard) begin
      pc_write = 1'b0;
      bubble   = 1'b1;
      if (stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
    end else begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign valid_out = valid_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Self-checking bench for if_id_stage against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] instr_in = 32'h0;
  logic        ex_MemRead = 1'b0;
  logic [4:0]  ex_rt = 5'd0;

  logic [31:0] pc_out, instr_out, pc_out4, instr_out4;
  logic [4:0]  rs, rt, rd, rs4, rt4, rd4;
  logic        valid_out, pc_write, bubble, valid_out4, pc_write4, bubble4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int failures = 0;

  // Behavioural model: architectural view of the IF/ID latch plus event tallies.
  logic [31:0] m_pc, m_instr;
  bit          m_valid;
  int          m_stalls, m_flushes;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .pc_in(pc_in), .instr_in(instr_in),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .pc_out(pc_out), .instr_out(instr_out),
    .rs(rs), .rt(rt), .rd(rd), .valid_out(valid_out), .pc_write(pc_write),
    .bubble(bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .pc_in(pc_in), .instr_in(instr_in),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .pc_out(pc_out4), .instr_out(instr_out4),
    .rs(rs4), .rt(rt4), .rd(rd4), .valid_out(valid_out4), .pc_write(pc_write4),
    .bubble(bubble4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  always #5 clk = ~clk;

  function automatic bit m_hazard();
    int r_s, r_t;
    r_s = (m_instr >> 21) % 32;
    r_t = (m_instr >> 16) % 32;
    return ex_MemRead && m_valid && (ex_rt != 0) && (ex_rt == r_s || ex_rt == r_t);
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  function automatic void m_reset();
    m_pc = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;
  endfunction

  function automatic void m_clock();
    if (PCSrc) begin
      m_pc = pc_in; m_instr = 0; m_valid = 0; m_flushes++;
    end else if (m_hazard()) begin
      m_stalls++;
    end else begin
      m_pc = pc_in; m_instr = instr_in; m_valid = 1;
    end
  endfunction

  task automatic drive(input bit src, input logic [31:0] pc, input logic [31:0] ins,
                       input bit mr, input logic [4:0] ert);
    @(negedge clk);
    PCSrc = src; pc_in = pc; instr_in = ins; ex_MemRead = mr; ex_rt = ert;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (instr_out !== 32'h0 || pc_out !== 32'h0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: pc=%h instr=%h valid=%b, want 0/0/0", pc_out, instr_out, valid_out);
    end
    checks++;
    if (pc_write !== 1'b1 || bubble !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_ctrl: pc_write=%b bubble=%b stall=%0d flush=%0d, want 1/0/0/0",
               pc_write, bubble, stall_cnt, flush_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_normal();
    drive(0, 32'h4, 32'h012A4020, 0, 5'd0);
    tick();
    checks++;
    if (pc_out !== 32'h4 || instr_out !== 32'h012A4020 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL normal_regs: pc=%h instr=%h valid=%b, want 4/012a4020/1", pc_out, instr_out, valid_out);
    end
    checks++;
    if (rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd8) begin
      failures++;
      $display("FAIL normal_fields: rs=%0d rt=%0d rd=%0d, want 9/10/8", rs, rt, rd);
    end
  endtask

  task automatic test_load_use();
    drive(0, 32'h8, 32'h01095020, 0, 5'd0);
    tick();
    drive(0, 32'hC, 32'hDEADBEEF, 1, 5'd8);
    checks++;
    if (pc_write !== 1'b0 || bubble !== 1'b1) begin
      failures++;
      $display("FAIL load_use_ctrl: pc_write=%b bubble=%b, want 0/1", pc_write, bubble);
    end
    tick();
    checks++;
    if (pc_out !== 32'h8 || instr_out !== 32'h01095020 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_hold: pc=%h instr=%h stall=%0d, want 8/01095020/1", pc_out, instr_out, stall_cnt);
    end
    drive(0, 32'hC, 32'hDEADBEEF, 0, 5'd8);
    checks++;
    if (pc_write !== 1'b1 || bubble !== 1'b0) begin
      failures++;
      $display("FAIL load_use_clear: pc_write=%b bubble=%b, want 1/0", pc_write, bubble);
    end
    tick();
    checks++;
    if (pc_out !== 32'hC || instr_out !== 32'hDEADBEEF || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_advance: pc=%h instr=%h stall=%0d, want c/deadbeef/1", pc_out, instr_out, stall_cnt);
    end
  endtask

  task automatic test_zero_exempt();
    drive(0, 32'h10, 32'h00084020, 0, 5'd0);
    tick();
    drive(0, 32'h14, 32'h00000000, 1, 5'd0);
    checks++;
    if (rs !== 5'd0 || pc_write !== 1'b1 || bubble !== 1'b0) begin
      failures++;
      $display("FAIL zero_exempt: rs=%0d pc_write=%b bubble=%b, want 0/1/0", rs, pc_write, bubble);
    end
    tick();
  endtask

  task automatic test_flush_priority();
    drive(0, 32'h18, 32'h01095020, 0, 5'd0);
    tick();
    drive(1, 32'h40, 32'h12345678, 1, 5'd8);
    checks++;
    if (pc_write !== 1'b1 || bubble !== 1'b0) begin
      failures++;
      $display("FAIL flush_ctrl: pc_write=%b bubble=%b, want 1/0", pc_write, bubble);
    end
    tick();
    checks++;
    if (instr_out !== 32'h0 || valid_out !== 1'b0 || pc_out !== 32'h40) begin
      failures++;
      $display("FAIL flush_regs: instr=%h valid=%b pc=%h, want 0/0/40", instr_out, valid_out, pc_out);
    end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== sat16(m_stalls)) begin
      failures++;
      $display("FAIL flush_cnts: flush=%0d stall=%0d, want 1/%0d", flush_cnt, stall_cnt, sat16(m_stalls));
    end
  endtask

  task automatic test_saturation();
    drive(0, 32'h44, 32'h01095020, 0, 5'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 32'h48, 32'hFFFFFFFF, 1, 5'd9);
      tick();
    end
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      failures++;
      $display("FAIL sat_stall4: got %0d want 15", stall_cnt4);
    end
    checks++;
    if (stall_cnt !== sat16(m_stalls) || instr_out !== 32'h01095020) begin
      failures++;
      $display("FAIL sat_stall16: stall=%0d instr=%h want %0d/01095020", stall_cnt, instr_out, sat16(m_stalls));
    end
  endtask

  task automatic test_mid_stall_reset();
    drive(0, 32'h48, 32'hFFFFFFFF, 1, 5'd9);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc_write !== 1'b1 || bubble !== 1'b0 ||
        stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      failures++;
      $display("FAIL midstall_reset: valid=%b instr=%h pw=%b bub=%b stall=%0d, want 0/0/1/0/0",
               valid_out, instr_out, pc_write, bubble, stall_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    drive(0, 32'h100, 32'h012A4020, 1, 5'd9);
    tick();
    checks++;
    if (pc_out !== 32'h100 || instr_out !== 32'h012A4020 || valid_out !== 1'b1 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midstall_resume: pc=%h instr=%h valid=%b stall=%0d, want 100/012a4020/1/0",
               pc_out, instr_out, valid_out, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] ert;
    bit exp_haz;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ert = m_instr[25:21];
        1:       ert = m_instr[20:16];
        2:       ert = 5'd0;
        default: ert = 5'($urandom);
      endcase
      drive(($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom_range(0, 1) == 1, ert);
      exp_haz = !PCSrc && m_hazard();
      checks++;
      if (pc_write !== !exp_haz || bubble !== exp_haz || pc_write4 !== !exp_haz) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: pc_write=%b bubble=%b, want %b/%b", i, pc_write, bubble, !exp_haz, exp_haz);
      end
      tick();
      checks++;
      if (pc_out !== m_pc || instr_out !== m_instr || valid_out !== m_valid ||
          rs !== m_instr[25:21] || rt !== m_instr[20:16] || rd !== m_instr[15:11]) begin
        failures++;
        $display("FAIL rand_regs[%0d]: pc=%h instr=%h valid=%b, want %h/%h/%b",
                 i, pc_out, instr_out, valid_out, m_pc, m_instr, m_valid);
      end
      checks++;
      if (stall_cnt !== sat16(m_stalls) || flush_cnt !== sat16(m_flushes) ||
          stall_cnt4 !== sat4(m_stalls) || flush_cnt4 !== sat4(m_flushes)) begin
        failures++;
        $display("FAIL rand_cnts[%0d]: stall=%0d/%0d flush=%0d/%0d, want %0d/%0d %0d/%0d", i,
                 stall_cnt, stall_cnt4, flush_cnt, flush_cnt4,
                 sat16(m_stalls), sat4(m_stalls), sat16(m_flushes), sat4(m_flushes));
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_normal();
    test_load_use();
    test_zero_exempt();
    test_flush_priority();
    test_saturation();
    test_mid_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage MIPS pipeline. It sits between instruction fetch and decode, directly upstream of the ID/EX register.
- Holds the fetched PC+4 and instruction, and detects load-use hazards against the instruction currently in ID/EX.
- Stalls the PC and IF/ID on a load-use hazard and requests a control bubble into ID/EX.
- Flushes itself when a branch is taken (PCSrc). Keeps saturating stall and flush event counters for debug.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction value loaded on reset/flush (sll $0,$0,0).
- CNT_W, 16, width of stall/flush event counters.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- PCSrc  in  1  branch taken (resolved in MEM); flush request.
- pc_in  in  32  PC+4 from IF.
- instr_in  in  32  instruction word from instruction memory.
- ex_MemRead  in  1  MemRead bit of ID/EX M field (instruction now in EX).
- ex_rt  in  5  rt field held in ID/EX (instr[20:16] of instruction in EX).
- pc_out  out  32  registered PC+4 to ID.
- instr_out  out  32  registered instruction to ID.
- rs  out  5  instr_out[25:21].
- rt  out  5  instr_out[20:16].
- rd  out  5  instr_out[15:11].
- valid_out  out  1  instr_out is a real fetched instruction (not reset/flush NOP).
- pc_write  out  1  PC register enable.
- bubble  out  1  zero the WB/M/EX controls written into ID/EX this cycle.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.
- flush_cnt  out  CNT_W  number of flush cycles, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): pc_out=0, instr_out=NOP_INSTR, valid_out=0, stall_cnt=0, flush_cnt=0. The combinational outputs follow from this: pc_write=1, bubble=0. Reset release takes effect on the next posedge.
- Hazard (combinational) = ex_MemRead & valid_out & (ex_rt != 0) & ((ex_rt == rs) | (ex_rt == rt)).
  - rt is compared for every opcode (conservative; no opcode decode).
- Per-posedge priority: PCSrc > hazard > normal.
  - PCSrc=1: pc_out<=pc_in, instr_out<=NOP_INSTR, valid_out<=0, flush_cnt++. Outputs pc_write=1, bubble=0 (ID/EX already zeroes its controls on PCSrc). A simultaneous hazard is ignored and stall_cnt is not incremented.
  - Hazard=1, PCSrc=0: pc_out, instr_out and valid_out hold. pc_write=0, bubble=1, stall_cnt++.
  - Otherwise: pc_out<=pc_in, instr_out<=instr_in, valid_out<=1. pc_write=1, bubble=0.
- Latency: 1 cycle from IF inputs to IF/ID outputs.
- A load-use stall lasts exactly 1 cycle: the next cycle ID/EX holds a bubble (MemRead=0), so the hazard clears.
- Back-to-back dependent loads (lw; lw using the first; use of the second) each produce exactly 1 stall.
- rs, rt and rd are pure slices of instr_out. They are valid whenever instr_out is; on NOP they are all 0.
- Counters saturate at 2^CNT_W-1 and do not wrap. Both counters are cleared only by reset.
- Reset asserted mid-stall: all state clears immediately. After release, fetch resumes normally; no residual stall.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset: rst_n=0 asynchronously between edges -> instr_out=0, pc_out=0, valid_out=0, pc_write=1, bubble=0, counters=0 without waiting for a clock.
- Normal flow: pc_in=0x4, instr_in=0x012A4020 (add $8,$9,$10) -> next posedge pc_out=0x4, instr_out=0x012A4020, rs=9, rt=10, rd=8, valid_out=1.
- Load-use: instr_out=0x01095020 (add $10,$8,$9), ex_MemRead=1, ex_rt=8 -> pc_write=0, bubble=1. Outputs hold 1 cycle, then with ex_MemRead=0 advance. stall_cnt=1.
- $0 exemption: ex_MemRead=1, ex_rt=0, instr_out rs=0 -> no stall, pc_write=1, bubble=0.
- Flush priority: PCSrc=1 with hazard active, pc_in=0x40 -> next posedge instr_out=0, valid_out=0, pc_out=0x40, flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=4, hold hazard condition for 20 cycles -> stall_cnt stops at 15.
